matmul_seq_accel: RTL and testbench

// Memory-mapped, sequential matrix-vector multiplier: computes y = a x B for an N-vector a and NxN matrix B.
// It uses one multiply-accumulate (MAC) unit, time-shared over N*N cycles.
// It sits on the same native CPU memory bus (valid/ready/wstrb) as the other accelerators.

---
 rtl/matmul_seq_accel_if.sv | 19 +
 rtl/matmul_seq_accel.sv | 165 ++++++++++++++++
 tb/tb_matmul_seq_accel.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_accel_if.sv
// rtl/matmul_seq_accel_if.sv - native CPU memory bus (valid/ready/wstrb) between CPU and accelerator
interface matmul_seq_accel_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/matmul_seq_accel.sv
// rtl/matmul_seq_accel.sv - memory-mapped sequential y = a x B using one time-shared MAC
module matmul_seq_accel #(
  parameter logic [31:0] ADDR_BASE    = 32'h0110_0000,
  parameter int          N            = 4,
  parameter int          INPUT_WIDTH  = 32,
  parameter int          RESULT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  matmul_seq_accel_if.slave     bus,
  output logic                  irq
);
  localparam int IW = INPUT_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int AW = $clog2(N);
  localparam int BW = $clog2(N * N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;
  logic busy, done;

  logic [IW-1:0] a_mem [N];
  logic [IW-1:0] b_mem [N*N];
  logic [RW-1:0] y_reg [N];
  logic [RW-1:0] sum;
  logic [AW-1:0] r_idx, c_idx;
  logic sgn, acc_m, ie, err;

  // Address decode; the 4 KiB window is matched on the upper 20 bits
  logic [11:0] off, a_off, b_off, y_off;
  logic in_win, accept, wr, rd;
  logic is_ctrl, is_stat, is_a, is_b, is_y;
  logic [AW-1:0] a_idx, y_idx;
  logic [BW-1:0] b_idx;
  logic y_hi;

  assign off     = bus.mem_addr[11:0];
  assign in_win  = (bus.mem_addr[31:12] == ADDR_BASE[31:12]);
  assign accept  = bus.mem_valid && in_win && !bus.mem_ready;
  assign wr      = accept && (bus.mem_wstrb != 4'b0000);
  assign rd      = accept && (bus.mem_wstrb == 4'b0000);
  assign a_off   = off - 12'h100;
  assign b_off   = off - 12'h200;
  assign y_off   = off - 12'h800;
  assign is_ctrl = (off[11:2] == 10'd0);
  assign is_stat = (off[11:2] == 10'd1);
  assign is_a    = (off >= 12'h100) && (off < 12'(256 + 4 * N));
  assign is_b    = (off >= 12'h200) && (off < 12'(512 + 4 * N * N));
  assign is_y    = (off >= 12'h800) && (off < 12'(2048 + 8 * N));
  assign a_idx   = AW'(a_off >> 2);
  assign b_idx   = BW'(b_off >> 2);
  assign y_idx   = AW'(y_off >> 3);
  assign y_hi    = y_off[2];

  logic start_wr, ctrl_wr, err_set, clr_err;
  assign ctrl_wr  = wr && is_ctrl;
  assign start_wr = ctrl_wr && bus.mem_wstrb[0] && bus.mem_wdata[0];
  assign clr_err  = ctrl_wr && bus.mem_wstrb[0] && bus.mem_wdata[4];
  assign err_set  = wr && busy && (is_a || is_b || is_ctrl);

  function automatic logic [IW-1:0] merge(input logic [IW-1:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] w;
    w = 32'(old);
    for (int k = 0; k < 4; k++)
      if (s[k]) w[8*k +: 8] = d[8*k +: 8];
    return IW'(w);
  endfunction

  function automatic logic [RW-1:0] ext(input logic [IW-1:0] v, input logic s);
    return s ? {{(RW-IW){v[IW-1]}}, v} : {{(RW-IW){1'b0}}, v};
  endfunction

  // MAC: b is stored column-major, so column c row r sits at c*N+r
  logic [BW-1:0] b_mac;
  logic [RW-1:0] prod, sum_next;
  logic last_r, last;

  assign b_mac    = BW'(c_idx) * BW'(N) + BW'(r_idx);
  assign prod     = ext(a_mem[r_idx], sgn) * ext(b_mem[b_mac], sgn);
  assign sum_next = ((r_idx == '0) ? '0 : sum) + prod;
  assign last_r   = (r_idx == AW'(N - 1));
  assign last     = last_r && (c_idx == AW'(N - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_wr) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (start_wr) state_n = RUN;
               else if (ctrl_wr) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign irq = done && ie;

  logic [31:0] rd_val;
  logic [63:0] y64;
  always_comb begin
    rd_val = '0;
    y64    = 64'(y_reg[y_idx]);
    if (is_ctrl)      rd_val = {28'd0, ie, acc_m, sgn, 1'b0};
    else if (is_stat) rd_val = {29'd0, err, done, busy};
    else if (is_a)    rd_val = 32'(a_mem[a_idx]);
    else if (is_b)    rd_val = 32'(b_mem[b_idx]);
    else if (is_y)    rd_val = y_hi ? y64[63:32] : y64[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      sgn   <= 1'b0;
      acc_m <= 1'b0;
      ie    <= 1'b0;
      err   <= 1'b0;
      r_idx <= '0;
      c_idx <= '0;
      sum   <= '0;
      for (int i = 0; i < N; i++) a_mem[i] <= '0;
      for (int i = 0; i < N*N; i++) b_mem[i] <= '0;
      for (int i = 0; i < N; i++) y_reg[i] <= '0;
    end else begin
      bus.mem_ready <= accept;
      if (rd) bus.mem_rdata <= rd_val;
      if (wr && is_a && !busy) a_mem[a_idx] <= merge(a_mem[a_idx], bus.mem_wdata, bus.mem_wstrb);
      if (wr && is_b && !busy) b_mem[b_idx] <= merge(b_mem[b_idx], bus.mem_wdata, bus.mem_wstrb);
      if (ctrl_wr && !busy && bus.mem_wstrb[0]) begin
        sgn   <= bus.mem_wdata[1];
        acc_m <= bus.mem_wdata[2];
        ie    <= bus.mem_wdata[3];
      end
      // A colliding clr_err loses to a same-edge error event
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (start_wr && !busy) begin
        r_idx <= '0;
        c_idx <= '0;
        if (!bus.mem_wdata[2])
          for (int i = 0; i < N; i++) y_reg[i] <= '0;
      end
      if (busy) begin
        sum   <= sum_next;
        r_idx <= last_r ? '0 : r_idx + 1'b1;
        if (last_r) begin
          y_reg[c_idx] <= y_reg[c_idx] + sum_next;
          c_idx        <= c_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matmul_seq_accel.sv
// tb/tb_matmul_seq_accel.sv - randomized self-checking bench for matmul_seq_accel
module tb_matmul_seq_accel;
  localparam logic [31:0] BASE = 32'h0110_0000;
  localparam logic [31:0] CTRL = BASE;
  localparam logic [31:0] STAT = BASE + 32'h4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic irq;
  int n_checks = 0;
  int n_pass = 0;

  matmul_seq_accel_if bus ();

  matmul_seq_accel dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] a_m [4];
  logic [31:0] b_m [4][4];
  logic [63:0] y_m [4];

  function automatic logic [31:0] a_addr(input int i);
    return BASE + 32'h100 + 32'(4 * i);
  endfunction
  function automatic logic [31:0] b_addr(input int r, input int c);
    return BASE + 32'h200 + 32'(4 * (c * 4 + r));
  endfunction
  function automatic logic [31:0] y_addr(input int c, input int hi);
    return BASE + 32'h800 + 32'(8 * c + 4 * hi);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_wstrb = strb;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("bus_ack", {63'd0, seen}, 64'd1);
    rdata = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_xfer(addr, data, strb, dummy);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_xfer(addr, 32'd0, 4'b0000, data);
  endtask

  task automatic set_a(input int i, input logic [31:0] v);
    bus_write(a_addr(i), v, 4'hF);
    a_m[i] = v;
  endtask
  task automatic set_b(input int r, input int c, input logic [31:0] v);
    bus_write(b_addr(r, c), v, 4'hF);
    b_m[r][c] = v;
  endtask

  function automatic logic [63:0] widen(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  task automatic model_run(input bit s, input bit acc);
    for (int c = 0; c < 4; c++) begin
      logic [63:0] t;
      t = 64'd0;
      for (int r = 0; r < 4; r++) t = t + widen(a_m[r], s) * widen(b_m[r][c], s);
      y_m[c] = acc ? y_m[c] + t : t;
    end
  endtask

  task automatic do_run(input bit s, input bit acc, output int cycles);
    bus_write(CTRL, {28'd0, 1'b1, acc, s, 1'b1}, 4'hF);
    cycles = 0;
    while (!irq && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    model_run(s, acc);
  endtask

  task automatic read_y(input int c, output logic [63:0] v);
    logic [31:0] lo, hi;
    bus_read(y_addr(c, 0), lo);
    bus_read(y_addr(c, 1), hi);
    v = {hi, lo};
  endtask

  task automatic load_t2;
    for (int r = 0; r < 4; r++) begin
      set_a(r, 32'(r + 1));
      for (int c = 0; c < 4; c++) set_b(r, c, 32'(c + 1));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] y;
    int cyc;
    int pulses;
    bit prev, consec, any;

    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    for (int i = 0; i < 4; i++) y_m[i] = 64'd0;

    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    check("rst_irq", {63'd0, irq}, 64'd0);
    bus_read(STAT, d);       check("rst_status", {32'd0, d}, 64'd0);
    bus_read(y_addr(0, 0), d); check("rst_y0", {32'd0, d}, 64'd0);
    bus_read(a_addr(0), d);  check("rst_a0", {32'd0, d}, 64'd0);

    load_t2();
    do_run(1'b0, 1'b0, cyc);
    check("t2_cycles", 64'(cyc), 64'd16);
    bus_read(STAT, d); check("t2_status", {32'd0, d}, 64'd2);
    for (int c = 0; c < 4; c++) begin
      read_y(c, y); check("t2_y", y, 64'(10 * (c + 1)));
    end

    for (int r = 0; r < 4; r++) begin
      set_a(r, 32'd0);
      for (int c = 0; c < 4; c++) set_b(r, c, 32'd0);
    end
    set_a(0, 32'hFFFF_FFFF);
    set_b(0, 0, 32'd2);
    do_run(1'b1, 1'b0, cyc);
    read_y(0, y); check("t3_signed", y, 64'hFFFF_FFFF_FFFF_FFFE);
    do_run(1'b0, 1'b0, cyc);
    read_y(0, y); check("t3_unsigned", y, 64'h0000_0001_FFFF_FFFE);

    load_t2();
    do_run(1'b0, 1'b0, cyc);
    do_run(1'b0, 1'b1, cyc);
    check("t4_cycles", 64'(cyc), 64'd16);
    check("t4_irq", {63'd0, irq}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      read_y(c, y); check("t4_y", y, 64'(20 * (c + 1)));
    end

    bus_write(CTRL, 32'h9, 4'hF);
    bus_write(a_addr(0), 32'd99, 4'hF);
    bus_write(CTRL, 32'h9, 4'hF);
    cyc = 0;
    while (!irq && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_done_seen", {63'd0, irq}, 64'd1);
    bus_read(STAT, d); check("t5_status_err", {32'd0, d}, 64'd6);
    for (int c = 0; c < 4; c++) begin
      read_y(c, y); check("t5_y", y, 64'(10 * (c + 1)));
    end
    bus_read(a_addr(0), d); check("t5_a0", {32'd0, d}, 64'd1);
    bus_write(CTRL, 32'h10, 4'hF);
    bus_read(STAT, d); check("t5_clr_err", {32'd0, d}, 64'd0);
    check("t5_irq_idle", {63'd0, irq}, 64'd0);

    for (int it = 0; it < 6; it++) begin
      bit s, acc;
      s   = 1'($urandom_range(0, 1));
      acc = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) begin
        set_a(r, (it % 2 == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128);
        for (int c = 0; c < 4; c++) set_b(r, c, (it % 3 == 0) ? $urandom : 32'($urandom_range(0, 1000)));
      end
      do_run(s, acc, cyc);
      check("rnd_cycles", 64'(cyc), 64'd16);
      for (int c = 0; c < 4; c++) begin
        read_y(c, y); check("rnd_y", y, y_m[c]);
      end
    end

    bus_write(a_addr(1), 32'd0, 4'hF);
    bus_write(a_addr(1), 32'hAABB_CCDD, 4'b0101);
    bus_read(a_addr(1), d); check("t6_strobe", {32'd0, d}, 64'h00BB_00DD);
    bus_read(BASE + 32'h40, d); check("t6_unmapped", {32'd0, d}, 64'd0);

    bus_read(a_addr(1), d);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h1000;
    bus.mem_wstrb = 4'b0000;
    any = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      any = any | bus.mem_ready;
    end
    bus.mem_valid = 1'b0;
    check("t6_oow_noack", {63'd0, any}, 64'd0);
    check("t6_oow_rdata", {32'd0, bus.mem_rdata}, 64'h00BB_00DD);

    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = STAT;
    pulses = 0; prev = 1'b0; consec = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.mem_ready) pulses++;
      if (bus.mem_ready && prev) consec = 1'b1;
      prev = bus.mem_ready;
    end
    bus.mem_valid = 1'b0;
    check("t6_hold_pulses", 64'(pulses), 64'd2);
    check("t6_no_consec", {63'd0, consec}, 64'd0);

    bus_write(CTRL, 32'h9, 4'hF);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_ready", {63'd0, bus.mem_ready}, 64'd0);
    check("t6_rst_rdata", {32'd0, bus.mem_rdata}, 64'd0);
    resetn = 1'b1;
    check("t6_rst_irq", {63'd0, irq}, 64'd0);
    bus_read(STAT, d); check("t6_rst_status", {32'd0, d}, 64'd0);
    bus_read(CTRL, d); check("t6_rst_ctrl", {32'd0, d}, 64'd0);
    bus_read(a_addr(1), d); check("t6_rst_a1", {32'd0, d}, 64'd0);
    bus_read(b_addr(0, 0), d); check("t6_rst_b00", {32'd0, d}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      read_y(c, y); check("t6_rst_y", y, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
